libnet_ack_gen_512: RTL

- Downstream consumer of the receive-side libnet sequence tracker's `seq_expected`/`seq_valid` outputs.
- Detects advances of the expected sequence number, coalesces them, and emits single-beat 512-bit ACK frames on an AXI-S master toward the sysnet TX path.
- Frame format matches the libnet header layout: seq at bits [375:344], ACK flag at bit 376, SYN flag at bit 377.

---
 rtl/libnet_pkg.sv | 32 +++
 rtl/libnet_ack_coalescer.sv | 58 +++++
 rtl/libnet_ack_gen_512.sv | 97 +++++++++
 3 files changed

// File: rtl/libnet_pkg.sv
// Shared constants, state type and helpers for the libnet ACK generator.
// Field positions follow the libnet header layout inside the 512-bit frame.
package libnet_pkg;

    localparam int FRAME_W  = 512;
    localparam int KEEP_W   = 64;
    localparam int HDR_BITS = 344;
    localparam int SEQ_W    = 32;
    localparam int SEQ_LSB  = 344;
    localparam int SEQ_MSB  = SEQ_LSB + SEQ_W - 1;
    localparam int ACK_FLAG = 376;
    localparam int SYN_FLAG = 377;
    localparam int CNT_W    = 16;
    localparam int TIMER_W  = 32;

    // 48 valid bytes: 43 header bytes plus seq and flags, rounded up.
    localparam logic [KEEP_W-1:0] ACK_TKEEP = 64'h0000_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ack_state_e;

    function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [TIMER_W-1:0] sat_inc32(input logic [TIMER_W-1:0] v);
        return (v == {TIMER_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/libnet_ack_coalescer.sv
// Tracks advances of the expected sequence number and decides when an ACK is due.
// frame_seq already reflects a same-cycle advance so a launch never misses it.
module libnet_ack_coalescer #(
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seq_in,
    input  logic        seq_valid,
    input  logic        clear,
    output logic        trigger,
    output logic [31:0] frame_seq
);
    import libnet_pkg::*;

    localparam logic [CNT_W-1:0]   COAL_TH = CNT_W'(ACK_COALESCE);
    localparam logic [TIMER_W-1:0] TMO_TH  = TIMER_W'(ACK_TIMEOUT - 1);

    logic               seen;
    logic [SEQ_W-1:0]   last_seen;
    logic               pending;
    logic [CNT_W-1:0]   pend_cnt;
    logic [TIMER_W-1:0] timer;
    logic               seq_event;

    assign seq_event = seq_valid && (!seen || (seq_in != last_seen));
    assign frame_seq = seq_event ? seq_in : last_seen;
    assign trigger   = pending && ((pend_cnt >= COAL_TH) || (timer >= TMO_TH));

    always_ff @(posedge clk) begin
        if (reset) begin
            seen      <= 1'b0;
            last_seen <= '0;
            pending   <= 1'b0;
            pend_cnt  <= '0;
            timer     <= '0;
        end else begin
            if (seq_event) begin
                last_seen <= seq_in;
                seen      <= 1'b1;
            end
            // A launch absorbs any advance arriving in the same cycle.
            if (clear) begin
                pending  <= 1'b0;
                pend_cnt <= '0;
                timer    <= '0;
            end else if (seq_event) begin
                pending  <= 1'b1;
                pend_cnt <= sat_inc16(pend_cnt);
                timer    <= pending ? sat_inc32(timer) : '0;
            end else if (pending) begin
                timer <= sat_inc32(timer);
            end
        end
    end

endmodule

// File: rtl/libnet_ack_gen_512.sv
// Builds single-beat 512-bit libnet ACK frames from coalesced sequence advances
// and presents them on an AXI-Stream master, holding each frame until accepted.
module libnet_ack_gen_512 #(
    parameter int ACK_COALESCE = 4,
    parameter int ACK_TIMEOUT  = 256,
    parameter int SEQ_LSB      = libnet_pkg::SEQ_LSB,
    parameter int ACK_FLAG     = libnet_pkg::ACK_FLAG,
    parameter int SYN_FLAG     = libnet_pkg::SYN_FLAG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  seq_in,
    input  logic         seq_valid,
    input  logic [343:0] hdr_template,
    output logic [511:0] tx_tdata,
    output logic [63:0]  tx_tkeep,
    output logic         tx_tvalid,
    output logic [63:0]  tx_tuser,
    output logic         tx_tlast,
    input  logic         tx_tready,
    output logic [31:0]  ack_count
);
    import libnet_pkg::*;

    ack_state_e         state;
    ack_state_e         state_next;
    logic               trigger;
    logic               launch;
    logic [SEQ_W-1:0]   frame_seq;
    logic [FRAME_W-1:0] frame;

    libnet_ack_coalescer #(
        .ACK_COALESCE (ACK_COALESCE),
        .ACK_TIMEOUT  (ACK_TIMEOUT)
    ) u_coalescer (
        .clk       (clk),
        .reset     (reset),
        .seq_in    (seq_in),
        .seq_valid (seq_valid),
        .clear     (launch),
        .trigger   (trigger),
        .frame_seq (frame_seq)
    );

    always_comb begin
        frame                         = '0;
        frame[HDR_BITS-1:0]           = hdr_template;
        frame[SEQ_LSB +: SEQ_W]       = frame_seq;
        frame[ACK_FLAG]               = 1'b1;
        frame[SYN_FLAG]               = 1'b0;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    launch     = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx_tvalid && tx_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_tdata  <= '0;
            tx_tkeep  <= '0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            ack_count <= '0;
        end else begin
            state <= state_next;
            if (launch) begin
                tx_tdata  <= frame;
                tx_tkeep  <= ACK_TKEEP;
                tx_tlast  <= 1'b1;
                tx_tvalid <= 1'b1;
            end else if ((state == SEND) && tx_tvalid && tx_tready) begin
                tx_tvalid <= 1'b0;
                tx_tlast  <= 1'b0;
                ack_count <= ack_count + 32'd1;
            end
        end
    end

    assign tx_tuser = '0;

endmodule
